dla_ifm_loader: RTL and testbench
=================================

// Module: dla_ifm_loader
// PURPOSE
//  Upstream feeder for the DLA core: copies a block of 32-bit words from a system-memory read port into a
//  DLA buffer (IFM0, IFM1 or weight regs) by driving the DLA's w_addr/w_data/ifm0_w_en/ifm1_w_en/weight_w_en.
//  Holds off writes to the IFM buffer the DLA is currently consuming, so loads ping-pong with computation.
//  Programmed by a start pulse with latched config; reports busy, done pulse and sticky err.
// PARAMETERS
//  DST_ADDR_W  12  width of destination word index placed on w_addr (upper w_addr bits driven 0)
//  LEN_W       12  width of word-count field
// PORTS
//  clk           in   1           DLA clock; single clock domain
//  rst           in   1           synchronous, active-high reset
//  cfg_src_addr  in   32          memory byte address of first word (sampled at start)
//  cfg_dst_addr  in   DST_ADDR_W  first destination word index (sampled at start)
//  cfg_len       in   LEN_W       number of words to copy (sampled at start)
//  cfg_target    in   2           00 IFM0, 01 IFM1, 10 WEIGHT, 11 reserved
//  start         in   1           1-cycle start pulse; honoured only in IDLE
//  abort         in   1           terminate current transfer
//  dla_busy      in   1           DLA computing (controller dla_active)
//  dla_buf_sel   in   1           IFM buffer the DLA is reading (0=IFM0, 1=IFM1)
//  mem_req       out  1           read request, held until mem_gnt
//  mem_addr      out  32          read byte address, stable while mem_req
//  mem_gnt       in   1           request accepted this cycle
//  mem_rvalid    in   1           read data valid (>=1 cycle after mem_gnt)
//  mem_rdata     in   32          read data
//  w_addr        out  32          DLA write address {0, dst index}
//  w_data        out  32          DLA write data
//  ifm0_w_en     out  4           IFM0 byte write enable, active low
//  ifm1_w_en     out  4           IFM1 byte write enable, active low
//  weight_w_en   out  4           weight write enable, active high
//  busy          out  1           high from accepted start until done
//  done          out  1           1-cycle completion pulse
//  err           out  1           sticky error; cleared by next accepted start
// BEHAVIOUR
//  Reset: IDLE; mem_req=0, mem_addr=0, w_addr=0, w_data=0, ifm0_w_en=ifm1_w_en=4'hf, weight_w_en=0,
//   busy=done=err=0. Outstanding read response after reset is ignored (rvalid ignored in IDLE).
//  FSM: IDLE -> HOLD -> REQ -> WAIT -> WR -> (HOLD | DONE); ABORT path via DRAIN.
//  IDLE: start=1 latches cfg, clears err, sets busy, word counter=0. cfg_len=0 -> DONE, no requests.
//   cfg_target=11 -> err=1, DONE, no requests. start outside IDLE ignored.
//  HOLD (evaluated before every word): stall while (target IFMx && dla_busy && dla_buf_sel==x) or
//   (target WEIGHT && dla_busy); else -> REQ. Never stalls mid-word.
//  REQ: mem_req=1, mem_addr=src+4*n; mem_gnt -> WAIT (mem_req low next cycle).
//  WAIT: mem_rvalid -> capture mem_rdata into w_data, w_addr=dst+n -> WR.
//  WR: exactly one cycle of selected enable (ifmX_w_en=4'h0 or weight_w_en=4'hf); others inactive.
//   n++; n==len -> DONE else HOLD. Min throughput 3 cycles/word (gnt in REQ, rvalid next cycle).
//  DONE: done=1 for one cycle, busy=0 next cycle -> IDLE. start in DONE cycle ignored.
//  Address arithmetic wraps modulo 2^32 (src) and 2^DST_ADDR_W (dst); no error on wrap.
//  abort in HOLD/REQ (before gnt): drop mem_req, err=1 -> DONE. abort in WAIT (or REQ with gnt same cycle):
//   -> DRAIN, wait for mem_rvalid, discard data, no write, err=1 -> DONE. abort in WR: write completes,
//   then DONE with err=1. abort in IDLE/DONE: ignored. abort and start same cycle in IDLE: start wins.
//  w_addr/w_data hold last value outside WR; enables inactive outside WR.
// TESTING
//  T1 reset: rst mid-WAIT, then rvalid -> no write strobe, all outputs at reset values, busy=0.
//  T2 IFM0 load: src=0x1000,dst=0,len=4, gnt immediate, rvalid +1 -> 4 strobes ifm0_w_en=0, w_addr 0..3,
//     mem_addr 0x1000..0x100C, done on cycle 13 after start, err=0.
//  T3 ping-pong hold: dla_busy=1,dla_buf_sel=1, target IFM1 len=2 -> no mem_req until dla_busy drops;
//     same with target IFM0 -> proceeds immediately.
//  T4 weight: target=10, len=9, gnt delayed 2 cycles -> 9 strobes weight_w_en=4'hf, mem_req held stable.
//  T5 abort in WAIT: rvalid 3 cycles later -> no write, done pulse after rvalid, err=1; next start clears err.
//  T6 corner: len=0 -> done 1 cycle after start, no mem_req; target=11 -> done with err=1.

Source files
------------

// File: rtl/dla_ifm_loader_if.sv
// -----------------------------------------------------------------------------
// dla_ifm_loader_if
//   Bus bundle between the IFM loader and the rest of the system: the
//   system-memory read port and the DLA buffer write port.
//
//   Memory read handshake: the master raises mem_req with mem_addr and holds
//   both stable until a cycle in which mem_gnt is high; that cycle transfers
//   the request. The response arrives later as a single-cycle mem_rvalid
//   pulse carrying mem_rdata. Responses cannot be back-pressured.
//
//   DLA write port: w_addr/w_data are qualified by the strobes. ifm0_w_en and
//   ifm1_w_en are active-low byte enables; weight_w_en is active-high.
//
//   master : the loader (drives requests and DLA writes)
//   slave  : memory responder / DLA buffers
// -----------------------------------------------------------------------------
interface dla_ifm_loader_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [3:0]  ifm0_w_en;
    logic [3:0]  ifm1_w_en;
    logic [3:0]  weight_w_en;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output w_addr, w_data, ifm0_w_en, ifm1_w_en, weight_w_en
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  w_addr, w_data, ifm0_w_en, ifm1_w_en, weight_w_en
    );
endinterface

// File: rtl/dla_ifm_loader.sv
// -----------------------------------------------------------------------------
// dla_ifm_loader
//   Copies a block of 32-bit words from a system-memory read port into one of
//   the DLA buffers (IFM0, IFM1 or the weight registers). Before every word it
//   checks whether the DLA is busy reading the targeted buffer and waits if
//   so, which lets a load into the idle IFM buffer overlap with computation on
//   the other one.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   cfg_src_addr    byte address of the first source word (latched at start)
//   cfg_dst_addr    first destination word index (latched at start)
//   cfg_len         number of words (latched at start)
//   cfg_target      00 IFM0, 01 IFM1, 10 WEIGHT, 11 reserved (error)
//   start           one-cycle start pulse, only honoured in IDLE
//   abort           terminate the current transfer
//   dla_busy        DLA is computing
//   dla_buf_sel     IFM buffer the DLA is reading (0 = IFM0, 1 = IFM1)
//   bus             memory read port + DLA write port (master side)
//   busy            high from the accepted start through the done cycle
//   done            one-cycle completion pulse
//   err             sticky error, cleared by the next accepted start
//   dbg_state_o     current FSM state
// -----------------------------------------------------------------------------
module dla_ifm_loader #(
    parameter int DST_ADDR_W = 12,
    parameter int LEN_W      = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           cfg_src_addr,
    input  logic [DST_ADDR_W-1:0] cfg_dst_addr,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic [1:0]            cfg_target,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  dla_busy,
    input  logic                  dla_buf_sel,
    dla_ifm_loader_if.master      bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            dbg_state_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HOLD  = 3'd1;
    localparam logic [2:0] ST_REQ   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_WR    = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_DRAIN = 3'd6;

    localparam logic [1:0] TGT_IFM0   = 2'b00;
    localparam logic [1:0] TGT_IFM1   = 2'b01;
    localparam logic [1:0] TGT_WEIGHT = 2'b10;
    localparam logic [1:0] TGT_RSVD   = 2'b11;

    logic [2:0]            state_q,  state_d;
    logic [1:0]            tgt_q,    tgt_d;
    logic [LEN_W-1:0]      len_q,    len_d;
    logic [LEN_W-1:0]      n_q,      n_d;
    logic [31:0]           src_q,    src_d;     // address of the current word
    logic [DST_ADDR_W-1:0] dst_q,    dst_d;     // index of the current word
    logic [DST_ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [31:0]           w_data_q, w_data_d;
    logic                  err_q,    err_d;

    logic                  hold_cur;
    logic                  hold_cfg;
    logic [LEN_W-1:0]      n_inc;

    // True when writing into tgt now would collide with the DLA reading it.
    function automatic logic must_hold(input logic [1:0] tgt,
                                       input logic       dbusy,
                                       input logic       sel);
        logic h;
        case (tgt)
            TGT_IFM0:   h = dbusy && !sel;
            TGT_IFM1:   h = dbusy && sel;
            TGT_WEIGHT: h = dbusy;
            default:    h = 1'b0;
        endcase
        return h;
    endfunction

    // The hold check is folded into the transitions out of IDLE and WR, so a
    // word that does not need to wait costs only REQ/WAIT/WR (3 cycles). The
    // HOLD state is only occupied while actually stalling.
    always_comb begin
        hold_cur = must_hold(tgt_q, dla_busy, dla_buf_sel);
        hold_cfg = must_hold(cfg_target, dla_busy, dla_buf_sel);
        n_inc    = n_q + 1'b1;

        state_d  = state_q;
        tgt_d    = tgt_q;
        len_d    = len_q;
        n_d      = n_q;
        src_d    = src_q;
        dst_d    = dst_q;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                // abort is ignored here, so start wins when both are high
                if (start) begin
                    tgt_d = cfg_target;
                    len_d = cfg_len;
                    n_d   = '0;
                    src_d = cfg_src_addr;
                    dst_d = cfg_dst_addr;
                    err_d = 1'b0;
                    if (cfg_target == TGT_RSVD) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (cfg_len == '0) begin
                        state_d = ST_DONE;
                    end else if (hold_cfg) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end

            ST_HOLD: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (!hold_cur) begin
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                // A grant in the same cycle as abort means a response is on
                // its way and must be drained before finishing.
                if (bus.mem_gnt) begin
                    state_d = abort ? ST_DRAIN : ST_WAIT;
                    if (abort) begin
                        err_d = 1'b1;
                    end
                end else if (abort) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_WAIT: begin
                if (abort) begin
                    // Data arriving together with abort is simply dropped.
                    err_d   = 1'b1;
                    state_d = bus.mem_rvalid ? ST_DONE : ST_DRAIN;
                end else if (bus.mem_rvalid) begin
                    w_data_d = bus.mem_rdata;
                    w_addr_d = dst_q;
                    state_d  = ST_WR;
                end
            end

            ST_DRAIN: begin
                if (bus.mem_rvalid) begin
                    state_d = ST_DONE;
                end
            end

            ST_WR: begin
                // Write strobe is active this cycle; advance to the next word.
                n_d   = n_inc;
                src_d = src_q + 32'd4;
                dst_d = dst_q + 1'b1;
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (n_inc == len_q) begin
                    state_d = ST_DONE;
                end else if (hold_cur) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_REQ;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tgt_q    <= TGT_IFM0;
            len_q    <= '0;
            n_q      <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            len_q    <= len_d;
            n_q      <= n_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            err_q    <= err_d;
        end
    end

    // All outputs decode directly from registered state, so none of them has
    // a combinational path from an input.
    assign bus.mem_req     = (state_q == ST_REQ);
    assign bus.mem_addr    = src_q;
    assign bus.w_addr      = 32'(w_addr_q);
    assign bus.w_data      = w_data_q;
    assign bus.ifm0_w_en   = (state_q == ST_WR && tgt_q == TGT_IFM0)   ? 4'h0 : 4'hf;
    assign bus.ifm1_w_en   = (state_q == ST_WR && tgt_q == TGT_IFM1)   ? 4'h0 : 4'hf;
    assign bus.weight_w_en = (state_q == ST_WR && tgt_q == TGT_WEIGHT) ? 4'hf : 4'h0;

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dla_ifm_loader.sv
// -----------------------------------------------------------------------------
// tb_dla_ifm_loader
//   Directed bench for dla_ifm_loader: a memory responder with programmable
//   grant/response latency, a write-strobe logger, and one task per scenario.
// -----------------------------------------------------------------------------
module tb_dla_ifm_loader;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HOLD  = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_WR    = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_DRAIN = 3'd6;

  localparam logic [11:0] EN_IFM0 = {4'h0, 4'hf, 4'h0};
  localparam logic [11:0] EN_IFM1 = {4'hf, 4'h0, 4'h0};
  localparam logic [11:0] EN_WGT  = {4'hf, 4'hf, 4'hf};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  logic [31:0] cfg_src_addr = '0;
  logic [11:0] cfg_dst_addr = '0;
  logic [11:0] cfg_len      = '0;
  logic [1:0]  cfg_target   = '0;
  logic        start = 1'b0, abort = 1'b0, dla_busy = 1'b0, dla_buf_sel = 1'b0;
  logic        busy, done, err;
  logic [2:0]  dbg_state;

  dla_ifm_loader_if bus();

  dla_ifm_loader #(.DST_ADDR_W(12), .LEN_W(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_src_addr (cfg_src_addr),
    .cfg_dst_addr (cfg_dst_addr),
    .cfg_len      (cfg_len),
    .cfg_target   (cfg_target),
    .start        (start),
    .abort        (abort),
    .dla_busy     (dla_busy),
    .dla_buf_sel  (dla_buf_sel),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .dbg_state_o  (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int start_cyc = 0;
  int done_at  = 0;

  bit mem_auto = 1'b0;
  int gnt_dly = 0;
  int rv_dly  = 0;
  int req_unstable = 0;
  int req_cycles   = 0;

  logic [31:0] gnt_addr_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [11:0] wr_en_q[$];
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    logic [31:0] a;
    forever begin
      if (mem_auto && bus.mem_req) begin
        a = bus.mem_addr;
        repeat (gnt_dly) begin
          @(posedge clk); #1;
          if (bus.mem_req !== 1'b1 || bus.mem_addr !== a) req_unstable++;
        end
        bus.mem_gnt = 1'b1;
        gnt_addr_q.push_back(a);
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        repeat (rv_dly) begin
          @(posedge clk); #1;
        end
        bus.mem_rdata  = data_of(a);
        bus.mem_rvalid = 1'b1;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // ---------------- write / request logger ----------------
  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) req_cycles++;
    if (bus.ifm0_w_en !== 4'hf || bus.ifm1_w_en !== 4'hf || bus.weight_w_en !== 4'h0) begin
      wr_en_q.push_back({bus.ifm0_w_en, bus.ifm1_w_en, bus.weight_w_en});
      wr_addr_q.push_back(bus.w_addr);
      wr_data_q.push_back(bus.w_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    gnt_addr_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_en_q.delete();
    exp_q.delete();
    req_cycles   = 0;
    req_unstable = 0;
  endtask

  // Returns one cycle after the edge that sampled start (cycle 1).
  task automatic do_start(input logic [31:0] src, input logic [11:0] dst,
                          input logic [11:0] len, input logic [1:0] tgt);
    cfg_src_addr = src;
    cfg_dst_addr = dst;
    cfg_len      = len;
    cfg_target   = tgt;
    start        = 1'b1;
    tick();
    start     = 1'b0;
    start_cyc = cyc_cnt;
  endtask

  // done_at = cycle index of the done pulse (start cycle = 0), -1 on timeout.
  task automatic wait_done(input int max_cyc);
    while (done !== 1'b1 && (cyc_cnt - start_cyc + 1) < max_cyc) tick();
    done_at = (done === 1'b1) ? (cyc_cnt - start_cyc + 1) : -1;
  endtask

  // Compare logged writes against exp_q (data) and an arithmetic address run.
  task automatic check_writes(input string name, input int count, input logic [11:0] en,
                              input logic [11:0] dst0, input logic [31:0] src0);
    logic [11:0] da;
    n_checks++;
    if (wr_en_q.size() !== count) begin
      n_fail++;
      $display("FAIL %s_write_count: got %0d want %0d", name, wr_en_q.size(), count);
    end
    for (int i = 0; i < count && i < wr_en_q.size(); i++) begin
      da = dst0 + 12'(i);
      n_checks++;
      if (wr_en_q[i] !== en) begin
        n_fail++;
        $display("FAIL %s_en[%0d]: got %h want %h", name, i, wr_en_q[i], en);
      end
      n_checks++;
      if (wr_addr_q[i] !== {20'h0, da}) begin
        n_fail++;
        $display("FAIL %s_w_addr[%0d]: got %h want %h", name, i, wr_addr_q[i], {20'h0, da});
      end
      n_checks++;
      if (wr_data_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_w_data[%0d]: got %h want %h", name, i, wr_data_q[i], exp_q[i]);
      end
      n_checks++;
      if (i < gnt_addr_q.size() && gnt_addr_q[i] !== src0 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL %s_mem_addr[%0d]: got %h want %h", name, i, gnt_addr_q[i], src0 + 32'(4 * i));
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    n_checks++; if (bus.w_addr !== 32'h0) begin n_fail++; $display("FAIL reset_w_addr: got %h want 0", bus.w_addr); end
    n_checks++; if (bus.w_data !== 32'h0) begin n_fail++; $display("FAIL reset_w_data: got %h want 0", bus.w_data); end
    n_checks++; if (bus.ifm0_w_en !== 4'hf) begin n_fail++; $display("FAIL reset_ifm0_w_en: got %h want f", bus.ifm0_w_en); end
    n_checks++; if (bus.ifm1_w_en !== 4'hf) begin n_fail++; $display("FAIL reset_ifm1_w_en: got %h want f", bus.ifm1_w_en); end
    n_checks++; if (bus.weight_w_en !== 4'h0) begin n_fail++; $display("FAIL reset_weight_w_en: got %h want 0", bus.weight_w_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_ifm0_load();
    clear_logs();
    mem_auto = 1'b1; gnt_dly = 0; rv_dly = 0; dla_busy = 1'b0;
    do_start(32'h1000, 12'h000, 12'd4, 2'b00);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ifm0_busy: got %b want 1", busy); end
    wait_done(40);
    n_checks++; if (done_at !== 13) begin n_fail++; $display("FAIL ifm0_done_cycle: got %0d want 13", done_at); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ifm0_err: got %b want 0", err); end
    for (int i = 0; i < 4; i++) exp_q.push_back(data_of(32'h1000 + 32'(4 * i)));
    check_writes("ifm0", 4, EN_IFM0, 12'h000, 32'h1000);
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ifm0_after_done: got done=%b busy=%b want 0 0", done, busy); end
    mem_auto = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    clear_logs();
    mem_auto = 1'b0;
    do_start(32'h2000, 12'h040, 12'd2, 2'b00);
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h2000) begin n_fail++; $display("FAIL rstwait_req: got req=%b addr=%h want 1 2000", bus.mem_req, bus.mem_addr); end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    n_checks++; if (dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL rstwait_in_wait: got %0d want %0d", dbg_state, ST_WAIT); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    bus.mem_rvalid = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    tick();
    n_checks++; if (wr_en_q.size() !== 0) begin n_fail++; $display("FAIL rstwait_no_write: got %0d writes want 0", wr_en_q.size()); end
    n_checks++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL rstwait_idle: got state=%0d busy=%b want 0 0", dbg_state, busy); end
    n_checks++; if (bus.w_addr !== 32'h0 || bus.w_data !== 32'h0) begin n_fail++; $display("FAIL rstwait_wbus: got %h %h want 0 0", bus.w_addr, bus.w_data); end
    n_checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rstwait_mem: got req=%b addr=%h want 0 0", bus.mem_req, bus.mem_addr); end
    n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rstwait_flags: got done=%b err=%b want 0 0", done, err); end
  endtask

  task automatic test_ping_pong();
    clear_logs();
    mem_auto = 1'b1; gnt_dly = 0; rv_dly = 0;
    dla_busy = 1'b1; dla_buf_sel = 1'b1;
    do_start(32'h0800, 12'h010, 12'd2, 2'b01);
    repeat (5) tick();
    n_checks++; if (dbg_state !== ST_HOLD) begin n_fail++; $display("FAIL pp_hold_state: got %0d want %0d", dbg_state, ST_HOLD); end
    n_checks++; if (req_cycles !== 0) begin n_fail++; $display("FAIL pp_no_req: got %0d req cycles want 0", req_cycles); end
    dla_busy = 1'b0;
    wait_done(40);
    n_checks++; if (done_at !== 13) begin n_fail++; $display("FAIL pp_done_cycle: got %0d want 13", done_at); end
    for (int i = 0; i < 2; i++) exp_q.push_back(data_of(32'h0800 + 32'(4 * i)));
    check_writes("pp_ifm1", 2, EN_IFM1, 12'h010, 32'h0800);
    tick();
    // DLA still on IFM1: a load into IFM0 must not wait
    clear_logs();
    dla_busy = 1'b1; dla_buf_sel = 1'b1;
    do_start(32'h0900, 12'h020, 12'd2, 2'b00);
    wait_done(40);
    n_checks++; if (done_at !== 7) begin n_fail++; $display("FAIL pp_ifm0_done_cycle: got %0d want 7", done_at); end
    for (int i = 0; i < 2; i++) exp_q.push_back(data_of(32'h0900 + 32'(4 * i)));
    check_writes("pp_ifm0", 2, EN_IFM0, 12'h020, 32'h0900);
    tick();
    // abort while holding: no request, done next cycle with err
    clear_logs();
    dla_buf_sel = 1'b0;
    do_start(32'h0A00, 12'h000, 12'd3, 2'b00);
    n_checks++; if (dbg_state !== ST_HOLD) begin n_fail++; $display("FAIL hold_abort_state: got %0d want %0d", dbg_state, ST_HOLD); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL hold_abort_done: got done=%b err=%b want 1 1", done, err); end
    n_checks++; if (req_cycles !== 0) begin n_fail++; $display("FAIL hold_abort_no_req: got %0d want 0", req_cycles); end
    tick();
    dla_busy = 1'b0;
    mem_auto = 1'b0;
  endtask

  task automatic test_weight();
    clear_logs();
    mem_auto = 1'b1; gnt_dly = 2; rv_dly = 0; dla_busy = 1'b0;
    // source and destination both wrap during this transfer
    do_start(32'hFFFF_FFF0, 12'hFFC, 12'd9, 2'b10);
    wait_done(80);
    n_checks++; if (done_at !== 46) begin n_fail++; $display("FAIL wgt_done_cycle: got %0d want 46", done_at); end
    n_checks++; if (req_unstable !== 0) begin n_fail++; $display("FAIL wgt_req_stable: got %0d unstable cycles want 0", req_unstable); end
    n_checks++; if (req_cycles !== 27) begin n_fail++; $display("FAIL wgt_req_cycles: got %0d want 27", req_cycles); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wgt_err: got %b want 0", err); end
    for (int i = 0; i < 9; i++) exp_q.push_back(data_of(32'hFFFF_FFF0 + 32'(4 * i)));
    check_writes("wgt", 9, EN_WGT, 12'hFFC, 32'hFFFF_FFF0);
    tick();
    gnt_dly = 0;
    mem_auto = 1'b0;
  endtask

  task automatic test_abort_wait();
    clear_logs();
    mem_auto = 1'b0;
    do_start(32'h3000, 12'h000, 12'd3, 2'b01);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (dbg_state !== ST_DRAIN || busy !== 1'b1) begin n_fail++; $display("FAIL abwait_drain: got state=%0d busy=%b want %0d 1", dbg_state, busy, ST_DRAIN); end
    tick();
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abwait_no_early_done: got %b want 0", done); end
    bus.mem_rdata  = 32'h1234_5678;
    bus.mem_rvalid = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    n_checks++; if (done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL abwait_done: got done=%b err=%b want 1 1", done, err); end
    n_checks++; if (wr_en_q.size() !== 0) begin n_fail++; $display("FAIL abwait_no_write: got %0d writes want 0", wr_en_q.size()); end
    tick();
    n_checks++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL abwait_sticky: got err=%b busy=%b want 1 0", err, busy); end
    // the next accepted start clears err
    clear_logs();
    mem_auto = 1'b1;
    do_start(32'h0040, 12'h005, 12'd1, 2'b00);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL abwait_err_clear: got %b want 0", err); end
    wait_done(20);
    n_checks++; if (done_at !== 4) begin n_fail++; $display("FAIL abwait_next_done: got %0d want 4", done_at); end
    exp_q.push_back(data_of(32'h0040));
    check_writes("abwait_next", 1, EN_IFM0, 12'h005, 32'h0040);
    tick();
    mem_auto = 1'b0;
  endtask

  task automatic test_abort_wr();
    int k;
    clear_logs();
    mem_auto = 1'b1; gnt_dly = 0; rv_dly = 0;
    do_start(32'h0500, 12'h020, 12'd3, 2'b01);
    k = 0;
    while (dbg_state !== ST_WR && k < 20) begin tick(); k++; end
    n_checks++; if (dbg_state !== ST_WR) begin n_fail++; $display("FAIL abwr_reach_wr: got %0d want %0d", dbg_state, ST_WR); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL abwr_done: got done=%b err=%b want 1 1", done, err); end
    exp_q.push_back(data_of(32'h0500));
    check_writes("abwr", 1, EN_IFM1, 12'h020, 32'h0500);
    tick();
    mem_auto = 1'b0;
  endtask

  task automatic test_corner();
    clear_logs();
    mem_auto = 1'b1;
    do_start(32'h0100, 12'h000, 12'd0, 2'b00);
    n_checks++; if (done !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL len0_done: got done=%b busy=%b err=%b want 1 1 0", done, busy, err); end
    // start during the done cycle is dropped
    cfg_len = 12'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored: got state=%0d busy=%b want 0 0", dbg_state, busy); end
    tick();
    n_checks++; if (req_cycles !== 0) begin n_fail++; $display("FAIL len0_no_req: got %0d want 0", req_cycles); end
    // reserved target
    do_start(32'h0100, 12'h000, 12'd5, 2'b11);
    n_checks++; if (done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL rsvd_done: got done=%b err=%b want 1 1", done, err); end
    tick();
    n_checks++; if (err !== 1'b1 || busy !== 1'b0 || req_cycles !== 0) begin n_fail++; $display("FAIL rsvd_after: got err=%b busy=%b req=%0d want 1 0 0", err, busy, req_cycles); end
    // start and abort together in IDLE: start wins
    clear_logs();
    abort = 1'b1;
    do_start(32'h0600, 12'h033, 12'd1, 2'b10);
    abort = 1'b0;
    wait_done(20);
    n_checks++; if (done_at !== 4 || err !== 1'b0) begin n_fail++; $display("FAIL start_abort: got done_at=%0d err=%b want 4 0", done_at, err); end
    exp_q.push_back(data_of(32'h0600));
    check_writes("start_abort", 1, EN_WGT, 12'h033, 32'h0600);
    tick();
    mem_auto = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    test_reset();
    test_ifm0_load();
    test_reset_mid_wait();
    test_ping_pong();
    test_weight();
    test_abort_wait();
    test_abort_wr();
    test_corner();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
